pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (pc, IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Resolves load-use hazards, multi-cycle MUL/DIV occupancy, I/D memory wait states and MEM-stage exception/eret redirects.
//  Drives per-stage write enables and flushes; owns the MDU busy counter. Sits beside the hazard/forwarding logic in the top.
// PARAMETERS
//  MUL_CYCLES  3   total stall cycles for mult/multu (>=2)
//  DIV_CYCLES  33  total stall cycles for div/divu (>=2)
// PORTS
//  clk          in   1  clock, all state on posedge
//  rst          in   1  reset, synchronous, active-low
//  ID_RS,ID_RT  in   5  source regs of instr in ID
//  ID_UseRS/RT  in   1  instr in ID reads RS / RT
//  EX_DMRd      in   1  instr in EX is a load
//  EX_RD        in   5  destination reg of instr in EX
//  md_start     in   1  MUL/DIV op present in EX (level)
//  md_is_div    in   1  1=div class, 0=mul class; valid with md_start
//  md_early_done in  1  MDU finished early (see CONFIGURATION)
//  imem_stall   in   1  instruction fetch not ready
//  dmem_stall   in   1  data access in MEM not ready
//  MEM_Exception in  1  exception committed in MEM
//  MEM_eret_flush in 1  eret committed in MEM
//  pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr  out 1  stage register write enables
//  if_flush, id_flush, ex_flush  out 1  bubble insertion into IF_ID / ID_EX / EX_MEM
//  exc_redirect out  1  select exception/EPC target as NPC this cycle
//  md_busy      out  1  state==BUSY
//  md_done      out  1  one-cycle pulse: MDU result valid, EX released
// BEHAVIOUR
//  State: IDLE, BUSY; cnt width $clog2(DIV_CYCLES). Reset (rst=0): state=IDLE, cnt=0; md_busy=0, md_done=0.
//  All enable/flush outputs combinational from state+inputs; default all wr=1, flushes=0, exc_redirect=0.
//  Priority, highest first (one class active per cycle):
//   1 exception: MEM_Exception|MEM_eret_flush -> pc_wr=1, exc_redirect=1, if_flush=id_flush=ex_flush=1,
//     ex_mem_wr=mem_wb_wr=1; BUSY aborted: next state=IDLE, cnt=0, md_done=0. Stall inputs ignored.
//   2 dmem_stall: pc_wr=if_id_wr=id_ex_wr=ex_mem_wr=mem_wb_wr=0, no flushes; state and cnt frozen.
//   3 MDU: IDLE & md_start -> load cnt=(md_is_div?DIV_CYCLES:MUL_CYCLES)-1, next=BUSY, stall this cycle.
//     BUSY & cnt!=0 -> cnt-=1, stall. Stall = pc_wr=if_id_wr=id_ex_wr=0, ex_flush=1 (bubble to MEM), EX held.
//     BUSY & cnt==0 -> md_done=1, no stall, next=IDLE. md_start ignored on md_done cycle (same instr leaving EX).
//     Total stall = N cycles, release on cycle N+1.
//   4 load-use: EX_DMRd & EX_RD!=0 & ((EX_RD==ID_RS & ID_UseRS)|(EX_RD==ID_RT & ID_UseRT))
//     -> pc_wr=if_id_wr=0, id_flush=1 (bubble), later stages advance. Exactly 1 cycle.
//   5 imem_stall: pc_wr=if_id_wr=0, if_flush... not asserted; id_flush=1 so ID bubble advances; later stages advance.
//  Load-use and imem_stall same cycle: load-use outputs (superset).
//  md_busy reflects registered state only; md_done never asserted in IDLE.
//  Reset mid-BUSY: IDLE next cycle, no md_done pulse.
// CONFIGURATION
//  MDU_EARLY_DONE_EN defined: BUSY & md_early_done & cnt!=0 -> cnt forced 0, next cycle is release cycle (md_done=1).
//    md_early_done in IDLE ignored. Exception/dmem_stall priority unchanged.
//  Undefined: md_early_done ignored; BUSY always runs full count.
// TESTING
//  T1 reset: rst=0 2 cycles -> md_busy=0, md_done=0, all wr=1, all flush=0, exc_redirect=0.
//  T2 load-use: EX_DMRd=1, EX_RD=5, ID_RS=5, ID_UseRS=1 -> 1 cycle pc_wr=if_id_wr=0, id_flush=1; next cycle all wr=1.
//  T3 div: md_start=1, md_is_div=1 -> 33 cycles pc_wr=0, ex_flush=1; md_done=1 on cycle 34; md_busy low after.
//  T4 exception mid-div: MEM_Exception=1 at BUSY cnt=10 -> exc_redirect=1, if/id/ex_flush=1; next cycle IDLE, no md_done.
//  T5 dmem_stall 4 cycles during mult BUSY -> all wr=0, cnt frozen; md_done 4 cycles later than T3-style baseline (cycle 8).
//  T6 MDU_EARLY_DONE_EN: div, md_early_done at BUSY cycle 5 -> md_done next cycle; macro off -> md_done still cycle 34.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the pc, IF_ID, ID_EX, EX_MEM and
// MEM_WB pipeline registers. It resolves load-use hazards, MUL/DIV occupancy,
// instruction/data memory wait states and MEM-stage exception/eret redirects.
// It also owns the MDU busy counter.
// Optional feature macro: MDU_EARLY_DONE_EN. When it is defined, md_early_done
// cuts a running MUL/DIV short. When it is undefined, every MUL/DIV op runs its
// full cycle count.
module pipe_stall_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_RS,
  input  logic [4:0] ID_RT,
  input  logic       ID_UseRS,
  input  logic       ID_UseRT,
  input  logic       EX_DMRd,
  input  logic [4:0] EX_RD,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       md_early_done,
  input  logic       imem_stall,
  input  logic       dmem_stall,
  input  logic       MEM_Exception,
  input  logic       MEM_eret_flush,
  output logic       pc_wr,
  output logic       if_id_wr,
  output logic       id_ex_wr,
  output logic       ex_mem_wr,
  output logic       mem_wb_wr,
  output logic       if_flush,
  output logic       id_flush,
  output logic       ex_flush,
  output logic       exc_redirect,
  output logic       md_busy,
  output logic       md_done
);

  // The counter is sized for the longer of the two op classes. It holds the
  // number of stall cycles still to come after the current one.
  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic w_exc;
  logic w_dstall;
  logic w_md_launch;
  logic w_md_wait;
  logic w_md_release;
  logic w_md_stall;
  logic w_early;
  logic w_load_use;
  logic w_fe_stall;

  // Classify the cycle once. Each class is masked by every class above it.
  assign w_exc        = MEM_Exception | MEM_eret_flush;
  assign w_dstall     = dmem_stall & ~w_exc;
  assign w_md_launch  = ~w_exc & ~dmem_stall & (r_state == IDLE) & md_start;
  assign w_md_wait    = ~w_exc & ~dmem_stall & (r_state == BUSY) & (r_cnt != '0);
  assign w_md_release = ~w_exc & ~dmem_stall & (r_state == BUSY) & (r_cnt == '0);
  assign w_md_stall   = w_md_launch | w_md_wait;

  assign w_load_use = EX_DMRd & (EX_RD != 5'd0) &
                      (((EX_RD == ID_RS) & ID_UseRS) | ((EX_RD == ID_RT) & ID_UseRT));
  // Load-use and an instruction fetch wait produce identical front-end
  // outputs, so the two share one path.
  assign w_fe_stall = ~w_exc & ~dmem_stall & ~w_md_stall & (w_load_use | imem_stall);

`ifdef MDU_EARLY_DONE_EN
  assign w_early = w_md_wait & md_early_done;
`else
  logic w_unused_early_done;
  assign w_unused_early_done = md_early_done;
  assign w_early = 1'b0;
`endif

  // Stage enables and bubbles, decoded from the cycle class.
  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    id_ex_wr     = 1'b1;
    ex_mem_wr    = 1'b1;
    mem_wb_wr    = 1'b1;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    ex_flush     = 1'b0;
    exc_redirect = 1'b0;
    if (w_exc) begin
      exc_redirect = 1'b1;
      if_flush     = 1'b1;
      id_flush     = 1'b1;
      ex_flush     = 1'b1;
    end else if (w_dstall) begin
      pc_wr     = 1'b0;
      if_id_wr  = 1'b0;
      id_ex_wr  = 1'b0;
      ex_mem_wr = 1'b0;
      mem_wb_wr = 1'b0;
    end else if (w_md_stall) begin
      // The MDU op stays in EX while a bubble drains into MEM.
      pc_wr    = 1'b0;
      if_id_wr = 1'b0;
      id_ex_wr = 1'b0;
      ex_flush = 1'b1;
    end else if (w_fe_stall) begin
      pc_wr    = 1'b0;
      if_id_wr = 1'b0;
      id_flush = 1'b1;
    end
  end

  // md_busy follows the registered state only. md_done is suppressed while
  // reset is held, so that a reset during BUSY never emits a done pulse.
  assign md_busy = (r_state == BUSY);
  assign md_done = w_md_release & rst;

  // MDU occupancy FSM: an exception aborts it, dmem_stall freezes it, and
  // otherwise the counter runs from the load value down to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (w_exc) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (!dmem_stall) begin
      if (r_state == IDLE) begin
        if (md_start) begin
          r_state <= BUSY;
          r_cnt   <= md_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end else if (r_cnt == '0) begin
        r_state <= IDLE;
      end else if (w_early) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule
